// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the phase-1 CPU hardwired control sequencer:
//   - opcode values (5-bit, IR[31:27])
//   - sequencer state encoding (RST, T0..T6, HALT)
//   - IR field bit positions (opcode, Ra, Rb, Rc)
package cpu_ctrl_pkg;

  // Opcodes
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Sequencer state encoding
  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  // IR field positions (MSB of each field)
  localparam int IR_OP_MSB = 31;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RC_MSB = 18;
  localparam int IR_REG_W  = 4;

endpackage

// File: rtl/op_decode.sv
// op_decode
// Combinational opcode classifier for the control sequencer.
// Build option: MULDIV_EN -- when defined, mul/div are ALU ops that use the
// extra HI write-back state; when undefined they classify as illegal.
// Ports:
//   opcode     in  OPW  opcode to classify
//   is_alu     out 1    instruction executes T3..T5 (incl. mul/div if enabled)
//   is_unary   out 1    neg/not: second operand comes from Rb, not Rc
//   is_muldiv  out 1    mul/div: writes LO in T5 and HI in T6
//   is_nop     out 1    nop
//   is_halt    out 1    halt
//   illegal    out 1    none of the above
module op_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output logic           is_alu,
  output logic           is_unary,
  output logic           is_muldiv,
  output logic           is_nop,
  output logic           is_halt,
  output logic           illegal
);

  always_comb begin
    is_alu    = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_SHR), OPW'(OP_SHRA), OPW'(OP_SHL),
      OPW'(OP_ROR), OPW'(OP_ROL), OPW'(OP_AND), OPW'(OP_OR): begin
        is_alu = 1'b1;
      end
      OPW'(OP_NEG), OPW'(OP_NOT): begin
        is_alu   = 1'b1;
        is_unary = 1'b1;
      end
      OPW'(OP_MUL), OPW'(OP_DIV): begin
`ifdef MULDIV_EN
        is_alu    = 1'b1;
        is_muldiv = 1'b1;
`else
        illegal   = 1'b1;
`endif
      end
      OPW'(OP_NOP):  is_nop  = 1'b1;
      OPW'(OP_HALT): is_halt = 1'b1;
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
// Hardwired control sequencer for the phase-1 CPU datapath. Fetches an
// instruction (T0..T2, with a Mem_ready handshake in T1), then sequences
// register-register ALU execution (T3..T5, plus T6 for mul/div).
// Build option: MULDIV_EN -- enables mul/div (T5 writes LO, T6 writes HI).
// Without it T6 is not built, mul/div halt as illegal, and HIin, LOin and
// ZHighout are constant 0.
// Ports:
//   Clock      in  1    system clock, rising edge
//   Reset_n    in  1    asynchronous active-low reset
//   IR         in  32   instruction register (opcode IR[31:27])
//   Mem_ready  in  1    memory read data valid (only looked at in T1)
//   Stop       in  1    halt at the next instruction boundary
//   PCout, Zlowout, ZHighout, MDRout                out  bus-drive strobes
//   MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  register loads
//   IncPC, Read                                     out  PC increment, mem read
//   Gra, Grb, Grc, Rin, Rout                        out  register select/encode
//   ALU_op     out OPW  ALU operation (nonzero only in T4)
//   Run        out 1    high in T0..T6
module alu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           Clock,
  input  logic           Reset_n,
  input  logic [31:0]    IR,
  input  logic           Mem_ready,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           ZHighout,
  output logic           MDRout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] ALU_op,
  output logic           Run
);

  logic [3:0]     state;
  logic [3:0]     state_nxt;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_sel;
  logic           is_alu, is_unary, is_muldiv, is_nop, is_halt, illegal;
  logic           unused_ir;

  // Only the opcode field is consumed; register fields go to the datapath
  // directly and are selected there by Gra/Grb/Grc.
  assign unused_ir = ^IR[IR_OP_MSB-OPW:0];

  // In T2 the opcode is not latched yet, so the branch after T2 decodes IR
  // directly; from T3 on the latched copy drives the decode.
  assign op_sel = (state == S_T2) ? IR[IR_OP_MSB -: OPW] : op_q;

  op_decode #(.OPW(OPW)) u_op_decode (
    .opcode    (op_sel),
    .is_alu    (is_alu),
    .is_unary  (is_unary),
    .is_muldiv (is_muldiv),
    .is_nop    (is_nop),
    .is_halt   (is_halt),
    .illegal   (illegal)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= S_RST;
    else          state <= state_nxt;
  end

  // Opcode captured on the T2->T3 edge
  always_ff @(posedge Clock) begin
    if (state == S_T2) op_q <= IR[IR_OP_MSB -: OPW];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (Mem_ready) state_nxt = S_T2;
      S_T2: begin
        if (is_alu)                  state_nxt = S_T3;
        else if (is_halt || illegal) state_nxt = S_HALT;
        else if (is_nop)             state_nxt = Stop ? S_HALT : S_T0;
        else                         state_nxt = S_HALT;
      end
      S_T3:   state_nxt = S_T4;
      S_T4:   state_nxt = S_T5;
      S_T5: begin
        if (is_muldiv) state_nxt = S_T6;
        else           state_nxt = Stop ? S_HALT : S_T0;
      end
`ifdef MULDIV_EN
      S_T6:   state_nxt = Stop ? S_HALT : S_T0;
`endif
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    ALU_op   = '0;
    Run      = 1'b0;
    case (state)
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        // PC+1 is held in Z across the wait; load PC only on the exit cycle
        Run = 1'b1; Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin = Mem_ready;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        Run = 1'b1; Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
      end
      S_T4: begin
        Run = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op_q;
        if (is_unary) Grb = 1'b1;
        else          Grc = 1'b1;
      end
      S_T5: begin
        Run = 1'b1; Zlowout = 1'b1;
`ifdef MULDIV_EN
        if (is_muldiv) LOin = 1'b1;
        else begin
          Gra = 1'b1; Rin = 1'b1;
        end
`else
        Gra = 1'b1; Rin = 1'b1;
`endif
      end
`ifdef MULDIV_EN
      S_T6: begin
        Run = 1'b1; ZHighout = 1'b1; HIin = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic [31:0] IR = '0;
  logic        Mem_ready = 1'b0;
  logic        Stop = 1'b0;
  logic PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
  logic HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run;
  logic [4:0] ALU_op;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  alu_ctrl_seq dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .ALU_op(ALU_op), .Run(Run)
  );

  logic [24:0] obs;
  assign obs = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run};

  localparam logic [24:0] B_PCOUT  = 25'h1 << 24;
  localparam logic [24:0] B_ZLOW   = 25'h1 << 23;
  localparam logic [24:0] B_ZHIGH  = 25'h1 << 22;
  localparam logic [24:0] B_MDROUT = 25'h1 << 21;
  localparam logic [24:0] B_MARIN  = 25'h1 << 20;
  localparam logic [24:0] B_PCIN   = 25'h1 << 19;
  localparam logic [24:0] B_MDRIN  = 25'h1 << 18;
  localparam logic [24:0] B_IRIN   = 25'h1 << 17;
  localparam logic [24:0] B_YIN    = 25'h1 << 16;
  localparam logic [24:0] B_ZIN    = 25'h1 << 15;
  localparam logic [24:0] B_HIIN   = 25'h1 << 14;
  localparam logic [24:0] B_LOIN   = 25'h1 << 13;
  localparam logic [24:0] B_INCPC  = 25'h1 << 12;
  localparam logic [24:0] B_READ   = 25'h1 << 11;
  localparam logic [24:0] B_GRA    = 25'h1 << 10;
  localparam logic [24:0] B_GRB    = 25'h1 << 9;
  localparam logic [24:0] B_GRC    = 25'h1 << 8;
  localparam logic [24:0] B_RIN    = 25'h1 << 7;
  localparam logic [24:0] B_ROUT   = 25'h1 << 6;
  localparam logic [24:0] B_RUN    = 25'h1;

  // Instruction kinds: 0 nop, 1 stops the machine (halt/illegal), 2 binary ALU,
  // 3 unary ALU, 4 mul/div
  function automatic int op_kind(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: return 2;
      5'b10001, 5'b10010: return 3;
      5'b01111, 5'b10000: begin
`ifdef MULDIV_EN
        return 4;
`else
        return 1;
`endif
      end
      5'b11010: return 0;
      default:  return 1;
    endcase
  endfunction

  logic [24:0] exp_q[$];
  int          mr_q[$];   // Mem_ready per cycle: 0, 1, or 2 = don't care (random)

  // Runs one instruction starting in T0, comparing every cycle with the trace
  // expected from the instruction rules. stop_from: Stop forced high from that
  // cycle index on. abort_at: cycle index where Reset_n is pulled low mid-cycle.
  task automatic run_instr(input logic [31:0] ir, input int d, input int stop_from,
                           input int abort_at, input string tag, output bit halted);
    int k;
    logic [4:0] op;
    op = ir[31:27];
    k = op_kind(op);
    IR = ir;
    exp_q.delete();
    mr_q.delete();
    exp_q.push_back(B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN); mr_q.push_back(2);
    for (int i = 0; i < d; i++) begin
      exp_q.push_back(B_ZLOW | B_READ | B_MDRIN | B_RUN); mr_q.push_back(0);
    end
    exp_q.push_back(B_ZLOW | B_READ | B_MDRIN | B_PCIN | B_RUN); mr_q.push_back(1);
    exp_q.push_back(B_MDROUT | B_IRIN | B_RUN); mr_q.push_back(2);
    if (k >= 2) begin
      exp_q.push_back(B_GRB | B_ROUT | B_YIN | B_RUN); mr_q.push_back(2);
      exp_q.push_back(B_ROUT | B_ZIN | B_RUN | {19'd0, op, 1'b0} | ((k == 3) ? B_GRB : B_GRC));
      mr_q.push_back(2);
      exp_q.push_back(B_ZLOW | B_RUN | ((k == 4) ? B_LOIN : (B_GRA | B_RIN))); mr_q.push_back(2);
      if (k == 4) begin
        exp_q.push_back(B_ZHIGH | B_HIIN | B_RUN); mr_q.push_back(2);
      end
    end
    halted = (k == 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      bit last;
      last = (i == exp_q.size() - 1);
      Mem_ready = (mr_q[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(mr_q[i]);
      if (i >= stop_from)      Stop = 1'b1;
      else if (!last || k == 1) Stop = 1'($urandom_range(0, 1));
      else                     Stop = 1'b0;
      if (last && Stop) halted = 1'b1;
      @(negedge Clock);
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL %s cycle %0d: outputs=%h expected=%h", tag, i, obs, exp_q[i]);
      end
      if (i == abort_at) begin
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 25'd0) begin
          failures++;
          $display("FAIL %s async_reset: outputs=%h expected=%h", tag, obs, 25'd0);
        end
        halted = 1'b1;
        return;
      end
      @(posedge Clock);
      #1;
    end
  endtask

  // Machine should sit in HALT with every output low whatever the inputs do
  task automatic check_halt(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      Mem_ready = 1'($urandom_range(0, 1));
      Stop = 1'($urandom_range(0, 1));
      @(negedge Clock);
      checks++;
      if (obs !== 25'd0) begin
        failures++;
        $display("FAIL %s halt cycle %0d: outputs=%h expected=%h", tag, i, obs, 25'd0);
      end
      @(posedge Clock);
      #1;
    end
  endtask

  // Reset pulse; leaves the bench #1 after the edge that enters T0
  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    Mem_ready = 1'b1;
    Stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (obs !== 25'd0) begin
        failures++;
        $display("FAIL %s in_reset: outputs=%h expected=%h", tag, obs, 25'd0);
      end
    end
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    @(negedge Clock);
    checks++;
    if (obs !== 25'd0) begin
      failures++;
      $display("FAIL %s rst_state: outputs=%h expected=%h", tag, obs, 25'd0);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic recover(input bit halted, input string tag);
    if (halted) begin
      check_halt(2, tag);
      do_reset(tag);
    end
  endtask

  task automatic test_reset();
    bit h;
    do_reset("reset");
    run_instr({5'b11010, 27'($urandom)}, 0, 99, -1, "reset_first_t0", h);
    recover(h, "reset_first_t0");
  endtask

  task automatic test_rol();
    bit h;
    run_instr(32'h4A920000, 0, 99, -1, "rol", h);
    recover(h, "rol");
  endtask

  task automatic test_mem_wait();
    bit h;
    run_instr({5'b00011, 27'($urandom)}, 3, 99, -1, "mem_wait", h);
    recover(h, "mem_wait");
  endtask

  task automatic test_muldiv();
    bit h;
    run_instr({5'b01111, 27'($urandom)}, 1, 99, -1, "mul", h);
    recover(h, "mul");
    run_instr({5'b10000, 27'($urandom)}, 0, 99, -1, "div", h);
    recover(h, "div");
  endtask

  task automatic test_stop();
    bit h;
    // add with Stop raised from T3 (index d+3) onward
    run_instr({5'b00011, 27'($urandom)}, 1, 4, -1, "stop_add", h);
    check_halt(4, "stop_add");
    do_reset("stop_add");
    // halt opcode with Stop also high: identical outcome
    run_instr({5'b11011, 27'($urandom)}, 0, 2, -1, "halt_and_stop", h);
    check_halt(3, "halt_and_stop");
    do_reset("halt_and_stop");
  endtask

  task automatic test_reset_mid();
    bit h;
    // abort in T4 (index d+4 with d=0)
    run_instr({5'b00100, 27'($urandom)}, 0, 99, 4, "reset_mid", h);
    do_reset("reset_mid");
    run_instr({5'b01010, 27'($urandom)}, 0, 99, -1, "after_reset_mid", h);
    recover(h, "after_reset_mid");
  endtask

  task automatic test_random();
    logic [4:0] ops[20];
    bit h;
    ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11010,
            5'b11011, 5'b00000, 5'b11111, 5'b01100, 5'b10001, 5'b00011};
    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      op = ops[$urandom_range(0, 19)];
      run_instr({op, 27'($urandom)}, int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 0 : 99, -1, "random", h);
      recover(h, "random");
    end
  endtask

  initial begin
    test_reset();
    test_rol();
    test_mem_wait();
    test_muldiv();
    test_stop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
